// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit - program-counter stage for the pipelined core.
//
// Holds the fetch address, generates the sequential next address, and applies
// branch/jump and exception redirects. A redirect that arrives while the stage
// is stalled is parked and issued when enable returns high.
// All state updates occur on the falling edge of clk. Reset is synchronous,
// active-high, sampled on that same falling edge.
//
// Optional feature macro: PC_ALIGN_TRAP_EN
//   undefined : low log2(INC) bits of a redirect target are masked to zero,
//               misalign is tied low.
//   defined   : a misaligned target is not taken; pc_out loads EXC_VECTOR and
//               misalign pulses for one cycle at the edge it would have loaded.
//
// Ports:
//   clk              in   clock (falling-edge active)
//   rst              in   synchronous active-high reset
//   enable           in   1 = advance, 0 = stall
//   redirect_valid   in   branch/jump taken this cycle
//   redirect_addr    in   branch/jump target [WIDTH]
//   exc_valid        in   exception, forces EXC_VECTOR
//   pc_out           out  current fetch address (registered) [WIDTH]
//   pc_plus          out  pc_out + INC, combinational, modulo 2^WIDTH [WIDTH]
//   pc_valid         out  pc_out is a valid fetch address
//   redirect_pending out  a redirect captured during a stall awaits issue
//   misalign         out  one-cycle pulse on trapped misaligned target
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
   parameter int unsigned      INC          = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_addr,
   input  logic             exc_valid,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus,
   output logic             pc_valid,
   output logic             redirect_pending,
   output logic             misalign
);

   // INC is a power of two, so INC-1 selects exactly the alignment bits.
   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);
   localparam logic [WIDTH-1:0] STEP     = WIDTH'(INC);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   logic [1:0]       r_state,      w_state_nxt;
   logic [WIDTH-1:0] r_pc,         w_pc_nxt;
   logic [WIDTH-1:0] r_pend_addr,  w_pend_addr_nxt;
   logic             r_pend_valid, w_pend_valid_nxt;
   logic             r_pc_valid,   w_pc_valid_nxt;
   logic [WIDTH-1:0] w_target;

   // A live redirect always beats a parked one.
   assign w_target = redirect_valid ? redirect_addr : r_pend_addr;

`ifdef PC_ALIGN_TRAP_EN
   logic r_misalign, w_misalign_nxt;
   logic w_target_bad;

   assign w_target_bad = |(w_target & LOW_MASK);
`endif

   // Next-state and next-value logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_pend_addr_nxt  = r_pend_addr;
      w_pend_valid_nxt = r_pend_valid;
      w_pc_valid_nxt   = r_pc_valid;
`ifdef PC_ALIGN_TRAP_EN
      w_misalign_nxt   = 1'b0;
`endif
      case (r_state)
         // First edge out of reset: fetch RESET_VECTOR, ignore all requests.
         S_BOOT: begin
            w_pc_valid_nxt = 1'b1;
            w_state_nxt    = S_RUN;
         end
         default: begin
            if (exc_valid) begin
               w_pc_nxt         = EXC_VECTOR;
               w_pend_valid_nxt = 1'b0;
               w_state_nxt      = S_RUN;
            end else if (!enable) begin
               w_state_nxt = S_STALL;
               if (redirect_valid) begin
                  w_pend_addr_nxt  = redirect_addr;
                  w_pend_valid_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = S_RUN;
               if (redirect_valid || r_pend_valid) begin
                  w_pend_valid_nxt = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
                  if (w_target_bad) begin
                     w_pc_nxt       = EXC_VECTOR;
                     w_misalign_nxt = 1'b1;
                  end else begin
                     w_pc_nxt = w_target;
                  end
`else
                  w_pc_nxt = w_target & ~LOW_MASK;
`endif
               end else begin
                  w_pc_nxt = r_pc + STEP;
               end
            end
         end
      endcase
   end

   // State registers, falling-edge with synchronous reset.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_state      <= S_BOOT;
         r_pc         <= RESET_VECTOR;
         r_pend_addr  <= '0;
         r_pend_valid <= 1'b0;
         r_pc_valid   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_pend_addr  <= w_pend_addr_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pc_valid   <= w_pc_valid_nxt;
      end
   end

`ifdef PC_ALIGN_TRAP_EN
   // Trap pulse register.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_misalign_nxt;
      end
   end

   assign misalign = r_misalign;
`else
   assign misalign = 1'b0;
`endif

   assign pc_out           = r_pc;
   assign pc_plus          = r_pc + STEP;
   assign pc_valid         = r_pc_valid;
   assign redirect_pending = r_pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit - self-checking bench for pc_unit (default parameters).
// Directed table, hand-written corner sequences, then random stimulus checked
// against a behavioural model of the PC rules.
// -----------------------------------------------------------------------------
module tb_pc_unit;

`ifdef PC_ALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        enable;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        exc_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus;
   logic        pc_valid;
   logic        redirect_pending;
   logic        misalign;

   int n_vec  = 0;
   int n_fail = 0;

   pc_unit dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .redirect_valid   (redirect_valid),
      .redirect_addr    (redirect_addr),
      .exc_valid        (exc_valid),
      .pc_out           (pc_out),
      .pc_plus          (pc_plus),
      .pc_valid         (pc_valid),
      .redirect_pending (redirect_pending),
      .misalign         (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: fetch address, valid flag, boot flag, parked redirect.
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_boot;
   logic        m_mis;
   logic [31:0] m_pend[$];

   task automatic m_take(input logic [31:0] t);
      if (TRAP && (t % 4) != 0) begin
         m_pc  = 32'h80;
         m_mis = 1'b1;
      end else begin
         m_pc = t - (t % 4);
      end
   endtask

   task automatic m_step();
      if (rst) begin
         m_pc = 32'h0; m_valid = 1'b0; m_boot = 1'b1; m_mis = 1'b0;
         m_pend.delete();
      end else if (m_boot) begin
         m_valid = 1'b1; m_boot = 1'b0; m_mis = 1'b0;
      end else begin
         m_mis = 1'b0;
         if (exc_valid) begin
            m_pc = 32'h80;
            m_pend.delete();
         end else if (!enable) begin
            if (redirect_valid) begin
               m_pend.delete();
               m_pend.push_back(redirect_addr);
            end
         end else if (redirect_valid) begin
            m_take(redirect_addr);
            m_pend.delete();
         end else if (m_pend.size() > 0) begin
            m_take(m_pend[0]);
            m_pend.delete();
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // Drive inputs away from the active (falling) edge, then sample 1 after it.
   task automatic apply(input logic a_rst, input logic a_en, input logic a_rv,
                        input logic [31:0] a_ra, input logic a_exc);
      @(posedge clk);
      rst = a_rst; enable = a_en; redirect_valid = a_rv;
      redirect_addr = a_ra; exc_valid = a_exc;
      @(negedge clk);
      m_step();
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] e_pc,
                        input logic e_valid, input logic e_pend, input logic e_mis);
      logic [31:0] e_plus;
      e_plus = e_pc + 32'd4;
      n_vec++;
      if (pc_out !== e_pc || pc_plus !== e_plus || pc_valid !== e_valid ||
          redirect_pending !== e_pend || misalign !== e_mis) begin
         n_fail++;
         $display("FAIL %s: got pc=%h plus=%h valid=%b pend=%b mis=%b, want pc=%h plus=%h valid=%b pend=%b mis=%b",
                  name, pc_out, pc_plus, pc_valid, redirect_pending, misalign,
                  e_pc, e_plus, e_valid, e_pend, e_mis);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        en;
      logic        rv;
      logic [31:0] ra;
      logic        exc;
      logic [31:0] pc;
      logic        valid;
      logic        pend;
   } vec_t;

   function automatic vec_t mk(logic r, logic e, logic v, logic [31:0] a, logic x,
                               logic [31:0] p, logic vl, logic pd);
      vec_t t;
      t.rst = r; t.en = e; t.rv = v; t.ra = a; t.exc = x;
      t.pc = p; t.valid = vl; t.pend = pd;
      return t;
   endfunction

   vec_t tbl[12];

   initial begin
      logic        r_rst, r_en, r_rv, r_exc;
      logic [31:0] r_ra;

      rst = 1'b1; enable = 1'b0; redirect_valid = 1'b0;
      redirect_addr = '0; exc_valid = 1'b0;
      m_pc = '0; m_valid = 1'b0; m_boot = 1'b1; m_mis = 1'b0;

      // Reset/boot, sequential stepping, stall with parked redirect.
      tbl[0]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0);
      tbl[1]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0);
      tbl[2]  = mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 0);
      tbl[3]  = mk(0, 1, 0, 32'h0,   0, 32'h4,   1, 0);
      tbl[4]  = mk(0, 1, 0, 32'h0,   0, 32'h8,   1, 0);
      tbl[5]  = mk(0, 1, 0, 32'h0,   0, 32'hC,   1, 0);
      tbl[6]  = mk(0, 1, 0, 32'h0,   0, 32'h10,  1, 0);
      tbl[7]  = mk(0, 0, 1, 32'h200, 0, 32'h10,  1, 1);
      tbl[8]  = mk(0, 0, 0, 32'h0,   0, 32'h10,  1, 1);
      tbl[9]  = mk(0, 0, 0, 32'h0,   0, 32'h10,  1, 1);
      tbl[10] = mk(0, 1, 0, 32'h0,   0, 32'h200, 1, 0);
      tbl[11] = mk(0, 1, 0, 32'h0,   0, 32'h204, 1, 0);

      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].rst, tbl[i].en, tbl[i].rv, tbl[i].ra, tbl[i].exc);
         check($sformatf("table[%0d]", i), tbl[i].pc, tbl[i].valid, tbl[i].pend, 1'b0);
      end

      // Overwrite and priority: newer parked redirect wins, live beats parked.
      apply(0, 0, 1, 32'h100, 0); check("prio_cap1", 32'h204, 1, 1, 0);
      apply(0, 0, 1, 32'h300, 0); check("prio_cap2", 32'h204, 1, 1, 0);
      apply(0, 1, 1, 32'h400, 0); check("prio_live", 32'h400, 1, 0, 0);
      apply(0, 0, 1, 32'h100, 0);
      apply(0, 0, 1, 32'h300, 0);
      apply(0, 1, 0, 32'h0,   0); check("prio_pend", 32'h300, 1, 0, 0);

      // Exception during a stall with a parked redirect.
      apply(0, 1, 1, 32'h40,  0); check("exc_setup", 32'h40, 1, 0, 0);
      apply(0, 0, 1, 32'h500, 0); check("exc_park",  32'h40, 1, 1, 0);
      apply(0, 0, 0, 32'h0,   1); check("exc_stall", 32'h80, 1, 0, 0);
      apply(0, 1, 0, 32'h0,   0); check("exc_next",  32'h84, 1, 0, 0);
      apply(0, 1, 1, 32'h600, 1); check("exc_live",  32'h80, 1, 0, 0);

      // Wrap at the top of the address space, then reset with a parked redirect.
      apply(0, 1, 1, 32'hFFFF_FFFC, 0); check("wrap_top", 32'hFFFF_FFFC, 1, 0, 0);
      apply(0, 1, 0, 32'h0,   0); check("wrap_zero",   32'h0, 1, 0, 0);
      apply(0, 0, 1, 32'h700, 0); check("rst_park",    32'h0, 1, 1, 0);
      apply(1, 0, 0, 32'h0,   0); check("rst_mid",     32'h0, 0, 0, 0);
      apply(0, 1, 1, 32'h900, 1); check("boot_ignore", 32'h0, 1, 0, 0);
      apply(0, 1, 0, 32'h0,   0); check("boot_next",   32'h4, 1, 0, 0);

      // Misaligned targets, direct and from a parked redirect.
      apply(0, 1, 1, 32'h102, 0);
      check("align_direct", TRAP ? 32'h80 : 32'h100, 1, 0, TRAP);
      apply(0, 1, 0, 32'h0, 0);
      check("align_after", TRAP ? 32'h84 : 32'h104, 1, 0, 1'b0);
      apply(0, 0, 1, 32'h206, 0);
      check("align_park", TRAP ? 32'h84 : 32'h104, 1, 1, 1'b0);
      apply(0, 1, 0, 32'h0, 0);
      check("align_issue", TRAP ? 32'h80 : 32'h204, 1, 0, TRAP);

      // Random stimulus against the model.
      for (int i = 0; i < 400; i++) begin
         r_rst = ($urandom_range(49, 0) == 0);
         r_en  = ($urandom_range(3, 0) != 0);
         r_rv  = ($urandom_range(3, 0) == 0);
         r_exc = ($urandom_range(19, 0) == 0);
         r_ra  = $urandom();
         if ($urandom_range(1, 0) == 1) r_ra[1:0] = 2'b00;
         apply(r_rst, r_en, r_rv, r_ra, r_exc);
         check($sformatf("rand[%0d]", i), m_pc, m_valid, (m_pend.size() > 0), m_mis);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
